// File: rtl/bcd_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : bcd_display_mux
// Description : Serial double-dabble binary-to-BCD converter driving a
//               time-multiplexed common-anode 7-segment display.
// Revision    : 1.0
// ============================================================================
module bcd_display_mux #(
  parameter int BIN_W       = 16,
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  output logic                busy,
  input  logic                blank_lz,
  input  logic [N_DIGITS-1:0] dp_sel,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic                dp,
  output logic [N_DIGITS-1:0] an
);

  localparam int c_bcd_w  = 4 * N_DIGITS + 4;
  localparam int c_disp_w = 4 * N_DIGITS;
  localparam int c_cnt_w  = $clog2(BIN_W + 1);
  localparam int c_idx_w  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int c_rc_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_ext_w  = (BIN_W > 32) ? BIN_W : 32;
  localparam logic [c_ext_w-1:0] c_limit = c_ext_w'(10 ** N_DIGITS);

  localparam logic [6:0] c_seg_zero  = 7'b1000000;
  localparam logic [6:0] c_seg_dash  = 7'b0111111;
  localparam logic [6:0] c_seg_blank = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [c_bcd_w-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic [c_disp_w-1:0]   disp_q, disp_d;
  logic [c_rc_w-1:0]     rcnt_q, rcnt_d;
  logic [c_idx_w-1:0]    idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [N_DIGITS-1:0]   lz;
  logic                  all_zero;
  logic [3:0]            nib;

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return c_seg_blank;
    endcase
  endfunction

  // Conversion engine: one binary bit enters the BCD register per SHIFT cycle.
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    disp_d     = disp_q;
    bcd_adj    = bcd_q;
    for (int i = 0; i < N_DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d      = value;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (c_ext_w'(value) >= c_limit);
          busy_d     = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        cnt_d          = cnt_q + 1'b1;
        if (cnt_q == c_cnt_w'(BIN_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        disp_d     = bcd_q[c_disp_w-1:0];
        overflow_d = ovf_pend_q;
        busy_d     = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // lz[i] is set when digits i..N_DIGITS-1 are all zero.
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero & (disp_q[4*i +: 4] == 4'd0);
      lz[i]    = all_zero;
    end
  end

  always_comb begin
    rcnt_d = rcnt_q + 1'b1;
    idx_d  = idx_q;
    if (rcnt_q == c_rc_w'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      idx_d  = (idx_q == c_idx_w'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    nib = disp_q[idx_q*4 +: 4];
    if (overflow_q) begin
      seg_d = c_seg_dash;
    end else if ((idx_q != '0) && blank_lz && lz[idx_q]) begin
      seg_d = c_seg_blank;
    end else begin
      seg_d = seg_decode(nib);
    end
    an_d = ~(N_DIGITS'(1) << idx_q);
    dp_d = ~dp_sel[idx_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
      rcnt_q     <= '0;
      idx_q      <= '0;
      seg_q      <= c_seg_zero;
      dp_q       <= 1'b1;
      an_q       <= ~N_DIGITS'(1);
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      rcnt_q     <= rcnt_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign an       = an_q;

endmodule
`default_nettype wire
